// File: rtl/tile_move_ctrl.sv
// Sequences one 2048 move over a 4x4 tile bank: for each of four lines it reads four
// tiles, compacts and merges them toward the move edge, then writes them back.
module tile_move_ctrl #(
  parameter int unsigned TILE_W  = 12,
  parameter int unsigned SCORE_W = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [1:0]         Dir,
  output logic [3:0]         Rd_Addr,
  input  logic [TILE_W-1:0]  Rd_Data,
  output logic [3:0]         Wr_Addr,
  output logic [TILE_W-1:0]  Wr_Data,
  output logic               Wr_En,
  output logic               Busy,
  output logic               Done,
  output logic               Moved,
  output logic               Win,
  output logic [SCORE_W-1:0] Score_Add
);

  localparam logic [TILE_W-1:0] MaxTile = TILE_W'(2048);

  typedef enum logic [2:0] {StIdle, StRead, StMerge, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic [1:0]          line_q, line_d;
  logic [1:0]          pos_q, pos_d;
  logic [TILE_W-1:0]   tiles_q [4];
  logic [TILE_W-1:0]   tiles_d [4];
  logic [TILE_W-1:0]   res_q [4];
  logic [TILE_W-1:0]   res_d [4];
  logic                moved_q, moved_d;
  logic                win_q, win_d;
  logic [SCORE_W-1:0]  score_q, score_d;

  // Merge datapath, evaluated on the latched line
  logic [TILE_W-1:0]   cmp [4];
  logic [TILE_W-1:0]   mrg [4];
  logic [TILE_W-1:0]   dbl;
  logic [2:0]          cnt;
  logic [2:0]          j;
  logic                skip;
  logic [SCORE_W-1:0]  mrg_score;
  logic                mrg_win;
  logic                mrg_diff;

  // k=0 is always the edge the tiles move toward
  function automatic logic [3:0] tile_idx(input logic [1:0] dir, input logic [1:0] line,
                                          input logic [1:0] pos);
    case (dir)
      2'd0:    tile_idx = {line, pos};
      2'd1:    tile_idx = {line, ~pos};
      2'd2:    tile_idx = {pos, line};
      default: tile_idx = {~pos, line};
    endcase
  endfunction

  always_comb begin
    cmp       = '{default: '0};
    mrg       = '{default: '0};
    cnt       = '0;
    j         = '0;
    skip      = 1'b0;
    dbl       = '0;
    mrg_score = '0;
    mrg_win   = 1'b0;
    mrg_diff  = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (tiles_q[i] != '0) begin
        cmp[cnt[1:0]] = tiles_q[i];
        cnt = cnt + 3'd1;
      end
    end

    // Leading edge first; a tile consumed by a merge is skipped so it merges at most once
    for (int i = 0; i < 3; i++) begin
      dbl = cmp[i] << 1;
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[i] == cmp[i+1] && cmp[i] != '0 && cmp[i] != MaxTile) begin
        mrg[j[1:0]] = dbl;
        mrg_score   = mrg_score + (SCORE_W'(cmp[i]) << 1);
        if (dbl == MaxTile) mrg_win = 1'b1;
        skip = 1'b1;
        j    = j + 3'd1;
      end else begin
        mrg[j[1:0]] = cmp[i];
        j = j + 3'd1;
      end
    end
    if (!skip) mrg[j[1:0]] = cmp[3];

    for (int i = 0; i < 4; i++) begin
      if (mrg[i] != tiles_q[i]) mrg_diff = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    line_d  = line_q;
    pos_d   = pos_q;
    tiles_d = tiles_q;
    res_d   = res_q;
    moved_d = moved_q;
    win_d   = win_q;
    score_d = score_q;
    Rd_Addr = '0;
    Wr_Addr = '0;
    Wr_Data = '0;
    Wr_En   = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;

    case (state_q)
      StIdle: begin
        if (Start) begin
          dir_d   = Dir;
          moved_d = 1'b0;
          win_d   = 1'b0;
          score_d = '0;
          line_d  = '0;
          pos_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        Busy           = 1'b1;
        Rd_Addr        = tile_idx(dir_q, line_q, pos_q);
        tiles_d[pos_q] = Rd_Data;
        pos_d          = pos_q + 2'd1;
        if (pos_q == 2'd3) state_d = StMerge;
      end
      StMerge: begin
        Busy    = 1'b1;
        res_d   = mrg;
        score_d = score_q + mrg_score;
        win_d   = win_q | mrg_win;
        moved_d = moved_q | mrg_diff;
        state_d = StWrite;
      end
      StWrite: begin
        Busy    = 1'b1;
        Wr_En   = 1'b1;
        Wr_Addr = tile_idx(dir_q, line_q, pos_q);
        Wr_Data = res_q[pos_q];
        pos_d   = pos_q + 2'd1;
        if (pos_q == 2'd3) begin
          if (line_q == 2'd3) begin
            state_d = StDone;
          end else begin
            line_d  = line_q + 2'd1;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        Done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      dir_q   <= '0;
      line_q  <= '0;
      pos_q   <= '0;
      moved_q <= 1'b0;
      win_q   <= 1'b0;
      score_q <= '0;
      for (int i = 0; i < 4; i++) begin
        tiles_q[i] <= '0;
        res_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      line_q  <= line_d;
      pos_q   <= pos_d;
      moved_q <= moved_d;
      win_q   <= win_d;
      score_q <= score_d;
      tiles_q <= tiles_d;
      res_q   <= res_d;
    end
  end

  assign Moved     = moved_q;
  assign Win       = win_q;
  assign Score_Add = score_q;

endmodule

// File: tb/tb_tile_move_ctrl.sv
// Directed bench for tile_move_ctrl: a behavioural 16-entry tile bank plus hand-computed
// expected boards, scores and flags.
module tb_tile_move_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Dir;
  logic [3:0]  Rd_Addr;
  logic [11:0] Rd_Data;
  logic [3:0]  Wr_Addr;
  logic [11:0] Wr_Data;
  logic        Wr_En;
  logic        Busy;
  logic        Done;
  logic        Moved;
  logic        Win;
  logic [15:0] Score_Add;

  logic [11:0] bank [16];
  logic [11:0] img [16];
  logic [11:0] exp_b [16];
  logic        bank_load = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int done_at, done_cnt, wr_cnt;

  tile_move_ctrl #(.TILE_W(12), .SCORE_W(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Dir       (Dir),
    .Rd_Addr   (Rd_Addr),
    .Rd_Data   (Rd_Data),
    .Wr_Addr   (Wr_Addr),
    .Wr_Data   (Wr_Data),
    .Wr_En     (Wr_En),
    .Busy      (Busy),
    .Done      (Done),
    .Moved     (Moved),
    .Win       (Win),
    .Score_Add (Score_Add)
  );

  always #5 Clk = ~Clk;

  assign Rd_Data = bank[Rd_Addr];

  always @(posedge Clk) begin
    if (bank_load) begin
      for (int i = 0; i < 16; i++) bank[i] <= img[i];
    end else if (Wr_En) begin
      bank[Wr_Addr] <= Wr_Data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic clear_imgs();
    for (int i = 0; i < 16; i++) begin
      img[i]   = '0;
      exp_b[i] = '0;
    end
  endtask

  task automatic load_bank();
    @(negedge Clk);
    bank_load = 1'b1;
    @(negedge Clk);
    bank_load = 1'b0;
  endtask

  task automatic check_board(input string name);
    for (int i = 0; i < 16; i++) check($sformatf("%s_t%0d", name, i), 32'(bank[i]), 32'(exp_b[i]));
  endtask

  // done_at counts edges after the one that sampled Start (36 means Done in cycle 37)
  task automatic do_move(input logic [1:0] d, input int extra_start_e);
    done_at  = -1;
    done_cnt = 0;
    wr_cnt   = 0;
    @(negedge Clk);
    Start = 1'b1;
    Dir   = d;
    @(negedge Clk);
    Start = 1'b0;
    check("busy_after_start", 32'(Busy), 32'd1);
    for (int e = 1; e <= 45; e++) begin
      if (Wr_En) wr_cnt++;
      Start = (e == extra_start_e);
      @(negedge Clk);
      if (Done) begin
        done_cnt++;
        done_at = e;
      end
    end
    Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Dir   = 2'd0;
    clear_imgs();
    bank_load = 1'b1;
    repeat (2) @(negedge Clk);
    bank_load = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_wren", 32'(Wr_En), 32'd0);
    check("rst_moved", 32'(Moved), 32'd0);
    check("rst_win", 32'(Win), 32'd0);
    check("rst_score", 32'(Score_Add), 32'd0);
    check("rst_rdaddr", 32'(Rd_Addr), 32'd0);
    check("rst_wraddr", 32'(Wr_Addr), 32'd0);
    check("rst_wrdata", 32'(Wr_Data), 32'd0);

    // Left: 2,2,4,4 -> 4,8,0,0
    clear_imgs();
    img[0] = 12'd2; img[1] = 12'd2; img[2] = 12'd4; img[3] = 12'd4;
    exp_b[0] = 12'd4; exp_b[1] = 12'd8;
    load_bank();
    do_move(2'd0, -1);
    check("l_latency", 32'(done_at), 32'd36);
    check("l_donecnt", 32'(done_cnt), 32'd1);
    check("l_wrcnt", 32'(wr_cnt), 32'd16);
    check("l_score", 32'(Score_Add), 32'd12);
    check("l_moved", 32'(Moved), 32'd1);
    check("l_win", 32'(Win), 32'd0);
    check("l_busy_idle", 32'(Busy), 32'd0);
    check_board("l");

    // Right: row1 2,2,2,0 -> 0,0,2,4
    clear_imgs();
    img[4] = 12'd2; img[5] = 12'd2; img[6] = 12'd2;
    exp_b[6] = 12'd2; exp_b[7] = 12'd4;
    load_bank();
    do_move(2'd1, -1);
    check("r_score", 32'(Score_Add), 32'd4);
    check("r_moved", 32'(Moved), 32'd1);
    check("r_win", 32'(Win), 32'd0);
    check_board("r");

    // Up: col2 2,4,8,16 already packed, nothing moves
    clear_imgs();
    img[2] = 12'd2; img[6] = 12'd4; img[10] = 12'd8; img[14] = 12'd16;
    exp_b[2] = 12'd2; exp_b[6] = 12'd4; exp_b[10] = 12'd8; exp_b[14] = 12'd16;
    load_bank();
    do_move(2'd2, -1);
    check("u_latency", 32'(done_at), 32'd36);
    check("u_score", 32'(Score_Add), 32'd0);
    check("u_moved", 32'(Moved), 32'd0);
    check_board("u");

    // Left: 1024,1024,2048,2048 -> 2048,2048,2048,0; the 2048 pair stays apart
    clear_imgs();
    img[12] = 12'd1024; img[13] = 12'd1024; img[14] = 12'd2048; img[15] = 12'd2048;
    exp_b[12] = 12'd2048; exp_b[13] = 12'd2048; exp_b[14] = 12'd2048;
    load_bank();
    do_move(2'd0, -1);
    check("w_score", 32'(Score_Add), 32'd2048);
    check("w_win", 32'(Win), 32'd1);
    check("w_moved", 32'(Moved), 32'd1);
    check_board("w");

    // Down: col0 2,0,0,2 -> 0,0,0,4 with a stray Start mid-move
    clear_imgs();
    img[0] = 12'd2; img[12] = 12'd2;
    exp_b[12] = 12'd4;
    load_bank();
    do_move(2'd3, 5);
    check("d_latency", 32'(done_at), 32'd36);
    check("d_donecnt", 32'(done_cnt), 32'd1);
    check("d_score", 32'(Score_Add), 32'd4);
    check("d_moved", 32'(Moved), 32'd1);
    check("d_win_cleared", 32'(Win), 32'd0);
    check_board("d");

    // Reset at edge 10: line 0 already written back, line 1 untouched
    clear_imgs();
    img[0] = 12'd2; img[1] = 12'd2; img[4] = 12'd4; img[5] = 12'd4;
    exp_b[0] = 12'd4; exp_b[4] = 12'd4; exp_b[5] = 12'd4;
    load_bank();
    @(negedge Clk);
    Start = 1'b1;
    Dir   = 2'd0;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("mr_busy", 32'(Busy), 32'd0);
    check("mr_wren", 32'(Wr_En), 32'd0);
    check("mr_score", 32'(Score_Add), 32'd0);
    done_cnt = 0;
    for (int e = 0; e < 40; e++) begin
      if (Done) done_cnt++;
      @(negedge Clk);
    end
    check("mr_nodone", 32'(done_cnt), 32'd0);
    check_board("mr");

    // Fresh move after the aborted one completes normally
    exp_b[0] = 12'd4; exp_b[4] = 12'd8; exp_b[5] = 12'd0;
    do_move(2'd0, -1);
    check("mr2_latency", 32'(done_at), 32'd36);
    check("mr2_score", 32'(Score_Add), 32'd8);
    check("mr2_moved", 32'(Moved), 32'd1);
    check_board("mr2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_move_ctrl.md
Name: tile_move_ctrl

Overview:
Sequences one 2048 board move over the 4x4 bank of 12-bit tile registers (register index = row*4+col, row 0 top, col 0 left). On Start it walks the four lines in the chosen direction. For each line it reads 4 tiles, compacts and merges them, then writes 4 tiles back through the bank's per-register Load strobes. It reports score gained, whether the board changed, and whether a 2048 tile was produced; the top-level game FSM uses these to decide spawn and win.

Parameters:
TILE_W, 12, tile value width (actual value 0,2,4..2048, not an exponent)
SCORE_W, 16, width of Score_Add

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  begin a move; sampled only in IDLE
Dir  in  2  0=left, 1=right, 2=up, 3=down; captured with Start
Rd_Addr  out  4  tile bank read index
Rd_Data  in  TILE_W  combinational read of bank[Rd_Addr], valid same cycle
Wr_Addr  out  4  tile bank write index
Wr_Data  out  TILE_W  value to load
Wr_En  out  1  Load strobe for bank[Wr_Addr], one register per cycle
Busy  out  1  high from the cycle after Start is accepted until Done
Done  out  1  one-cycle pulse when the move completes
Moved  out  1  any tile changed; valid with Done, held until next Start
Win  out  1  a merge produced 2048; valid with Done, held until next Start
Score_Add  out  SCORE_W  sum of merged tile values this move; valid with Done, held until next Start

Behaviour:
- Reset has one clock, and reset is synchronous and active-high. Reset state: state=IDLE, Busy=0, Done=0, Wr_En=0, Moved=0, Win=0, Score_Add=0, Rd_Addr=0, Wr_Addr=0, Wr_Data=0, line/pos counters=0. Reset overrides all other inputs in every state.
- States: IDLE, READ, MERGE, WRITE, DONE.
- IDLE: when Start=1, capture Dir and clear Moved, Win and Score_Add; go to READ with line L=0, pos k=0. While not in IDLE, Start is ignored.
- Position map for line L, pos k (k=0 is the edge tiles move toward): left 4L+k; right 4L+3-k; up 4k+L; down 4(3-k)+L.
- READ: Rd_Addr = map(L,k); latch Rd_Data into buf[k]. k goes 0..3, 4 cycles, then MERGE.
- MERGE, 1 cycle:
  - Compact the nonzero entries of buf toward k=0, preserving order.
  - Scan i=0..2: if c[i]==c[i+1], c[i]!=0 and c[i]!=2048, then out gets 2*c[i], Score_Add += 2*c[i], and skip c[i+1]. Otherwise out gets c[i].
  - Each tile merges at most once. Merging is leading-edge first, so 2,2,2 gives 4,2 and 2,2,2,2 gives 4,4.
  - 2048 tiles never merge. Any merge result of 2048 sets Win.
  - Pad out with zeros to 4 entries.
  - If out differs from buf in any position, set Moved.
- WRITE: Wr_En=1, Wr_Addr=map(L,k), Wr_Data=out[k]. k goes 0..3, 4 cycles; all 4 positions are written even if unchanged. Then if L<3: L++, k=0, go to READ; else go to DONE.
- DONE: Done=1 for one cycle, Busy=0, then IDLE.
- Latency: Start sampled at edge 0; 4 lines x 9 cycles = 36 busy cycles; Done is high in cycle 37.
- Wr_En is 0 in every state other than WRITE.
- Score_Add maximum is 8x2048=16384; no overflow is possible at SCORE_W=16.
- Reset mid-move: the next cycle is IDLE with no Done, and writes already made remain in the bank.

Test Plan:
- Left, row0=2,2,4,4, rest 0, Start -> row0=4,8,0,0; Score_Add=12, Moved=1, Win=0; Done exactly 37 cycles after Start; exactly 16 Wr_En cycles.
- Right, row1=2,2,2,0 -> row1=0,0,2,4; Score_Add=4, Moved=1.
- Up, col2 (rows 0..3)=2,4,8,16, rest 0 -> board unchanged; Moved=0, Score_Add=0, Done still at cycle 37.
- Left, row3=1024,1024,2048,2048 -> row3=2048,2048,2048,0; Win=1, Score_Add=2048; the existing 2048 pair does not merge.
- Down, col0 (rows 0..3)=2,0,0,2 -> col0=0,0,0,4; Score_Add=4. A second Start pulsed at cycle 5 is ignored and Done pulses once.
- Start a move, assert Reset at cycle 10 for 1 cycle -> next cycle Busy=0, Wr_En=0, Score_Add=0, and Done never pulses. A new Start then completes normally.
